// File: rtl/fc_ibuf_sliced_if.sv
`default_nettype none
// ============================================================================
// Module   : fc_ibuf_sliced_if
// Brief    : Handshake and bus bundle for the bit-sliced FC input buffer.
//            The slave modport is the buffer side. The master modport is the
//            producer/consumer side.
// Revision : 1.0 - initial release
// ============================================================================
interface fc_ibuf_sliced_if #(
  parameter int DATA_SIZE       = 8,
  parameter int SLICE_BITS      = 1,
  parameter int NUM_CHANNELS    = 2,
  parameter int H_CIM_TILES_IN  = 4,
  parameter int FIFO_LENGTH     = 16,
  parameter int BUS_WIDTH       = 16,
  parameter int V_CIM_TILES_OUT = 1
);
  localparam int E          = FIFO_LENGTH * H_CIM_TILES_IN * NUM_CHANNELS;
  localparam int OUT_W      = BUS_WIDTH * V_CIM_TILES_OUT;
  localparam int NUM_SLICES = DATA_SIZE / SLICE_BITS;
  localparam int NUM_ADDR   = (E * SLICE_BITS + OUT_W - 1) / OUT_W;
  localparam int ADDR_W     = (NUM_ADDR > 1) ? $clog2(NUM_ADDR) : 1;
  localparam int SLICE_W    = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;

  logic                                                         i_flush;
  logic                                                         i_wr_valid;
  logic                                                         o_wr_ready;
  logic [H_CIM_TILES_IN-1:0][NUM_CHANNELS-1:0][DATA_SIZE-1:0]   i_wr_data;
  logic                                                         o_rd_valid;
  logic                                                         i_rd_ready;
  logic [OUT_W-1:0]                                             o_rd_data;
  logic [ADDR_W-1:0]                                            o_rd_addr;
  logic [SLICE_W-1:0]                                           o_rd_slice;
  logic                                                         o_rd_last;

  modport slave (
    input  i_flush, i_wr_valid, i_wr_data, i_rd_ready,
    output o_wr_ready, o_rd_valid, o_rd_data, o_rd_addr, o_rd_slice, o_rd_last
  );

  modport master (
    output i_flush, i_wr_valid, i_wr_data, i_rd_ready,
    input  o_wr_ready, o_rd_valid, o_rd_data, o_rd_addr, o_rd_slice, o_rd_last
  );
endinterface
`default_nettype wire

// File: rtl/fc_ibuf_sliced.sv
`default_nettype none
// ============================================================================
// Module   : fc_ibuf_sliced
// Brief    : FC input buffer. Collects FIFO_LENGTH column beats, then streams
//            the activations bit-sliced as OUT_W-bit words to the crossbar.
//            Optional macro IBUF_MSB_FIRST_EN emits slices MSB-first.
// Revision : 1.0 - initial release
// ============================================================================
module fc_ibuf_sliced #(
  parameter int DATA_SIZE       = 8,
  parameter int SLICE_BITS      = 1,
  parameter int NUM_CHANNELS    = 2,
  parameter int H_CIM_TILES_IN  = 4,
  parameter int FIFO_LENGTH     = 16,
  parameter int BUS_WIDTH       = 16,
  parameter int V_CIM_TILES_OUT = 1
) (
  input  logic           clk,
  input  logic           rst,
  fc_ibuf_sliced_if.slave bus
);
  localparam int E          = FIFO_LENGTH * H_CIM_TILES_IN * NUM_CHANNELS;
  localparam int OUT_W      = BUS_WIDTH * V_CIM_TILES_OUT;
  localparam int NUM_SLICES = DATA_SIZE / SLICE_BITS;
  localparam int NUM_ADDR   = (E * SLICE_BITS + OUT_W - 1) / OUT_W;
  localparam int FLAT_W     = NUM_ADDR * OUT_W;
  localparam int ELEM_BITS  = E * SLICE_BITS;
  localparam int ADDR_W     = (NUM_ADDR > 1) ? $clog2(NUM_ADDR) : 1;
  localparam int SLICE_W    = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam int WP_W       = (FIFO_LENGTH > 1) ? $clog2(FIFO_LENGTH) : 1;

  // A last-value of 0 makes the matching counter stay at 0 (degenerate case).
  localparam logic [ADDR_W-1:0]  c_ADDR_LAST  = ADDR_W'(NUM_ADDR - 1);
  localparam logic [SLICE_W-1:0] c_SLICE_LAST = SLICE_W'(NUM_SLICES - 1);
  localparam logic [WP_W-1:0]    c_WP_LAST    = WP_W'(FIFO_LENGTH - 1);

  typedef logic [H_CIM_TILES_IN-1:0][NUM_CHANNELS-1:0][DATA_SIZE-1:0] beat_t;
  typedef enum logic [0:0] {FILL = 1'b0, STREAM = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [WP_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [SLICE_W-1:0]  slice_q, slice_d;
  beat_t               mem_q [FIFO_LENGTH];

  logic                wr_ready;
  logic                rd_valid;
  logic                wr_fire;
  logic                rd_fire;
  logic                wr_en;
  logic [SLICE_W-1:0]  slice_phys;
  logic [31:0]         elem_shamt;
  logic [31:0]         word_shamt;
  logic [FLAT_W-1:0]   flat;
  logic [OUT_W-1:0]    word;

  assign wr_ready = (state_q == FILL);
  assign rd_valid = (state_q == STREAM);
  assign wr_fire  = bus.i_wr_valid && wr_ready;
  assign rd_fire  = rd_valid && bus.i_rd_ready;
  // A flush drops any beat arriving in the same cycle.
  assign wr_en    = wr_fire && !bus.i_flush;

`ifdef IBUF_MSB_FIRST_EN
  assign slice_phys = c_SLICE_LAST - slice_q;
`else
  assign slice_phys = slice_q;
`endif

  // Flat slice vector: each element contributes SLICE_BITS bits taken from
  // its physical slice, placed at element index e=(k*NC+j)*H+i.
  assign elem_shamt = 32'(slice_phys) * 32'(SLICE_BITS);

  for (genvar k = 0; k < FIFO_LENGTH; k++) begin : g_col
    for (genvar j = 0; j < NUM_CHANNELS; j++) begin : g_chan
      for (genvar i = 0; i < H_CIM_TILES_IN; i++) begin : g_tile
        localparam int EI = (k * NUM_CHANNELS + j) * H_CIM_TILES_IN + i;
        assign flat[EI*SLICE_BITS +: SLICE_BITS] = SLICE_BITS'(mem_q[k][i][j] >> elem_shamt);
      end
    end
  end

  if (FLAT_W > ELEM_BITS) begin : g_pad
    assign flat[FLAT_W-1:ELEM_BITS] = '0;
  end

  assign word_shamt = 32'(addr_q) * 32'(OUT_W);
  assign word       = OUT_W'(flat >> word_shamt);

  assign bus.o_wr_ready = wr_ready;
  assign bus.o_rd_valid = rd_valid;
  assign bus.o_rd_data  = rd_valid ? word : '0;
  assign bus.o_rd_addr  = addr_q;
  // Slice index is only meaningful while streaming; it reads 0 otherwise.
  assign bus.o_rd_slice = rd_valid ? slice_phys : '0;
  assign bus.o_rd_last  = rd_valid && (addr_q == c_ADDR_LAST) && (slice_q == c_SLICE_LAST);

  // Next-state and sequencing counters; flush overrides every handshake.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    addr_d   = addr_q;
    slice_d  = slice_q;
    if (bus.i_flush) begin
      state_d  = FILL;
      wr_ptr_d = '0;
      addr_d   = '0;
      slice_d  = '0;
    end else begin
      case (state_q)
        FILL: begin
          if (wr_fire) begin
            if (wr_ptr_q == c_WP_LAST) begin
              wr_ptr_d = '0;
              state_d  = STREAM;
            end else begin
              wr_ptr_d = wr_ptr_q + WP_W'(1);
            end
          end
        end
        STREAM: begin
          if (rd_fire) begin
            if (addr_q == c_ADDR_LAST) begin
              addr_d = '0;
              if (slice_q == c_SLICE_LAST) begin
                slice_d = '0;
                state_d = FILL;
              end else begin
                slice_d = slice_q + SLICE_W'(1);
              end
            end else begin
              addr_d = addr_q + ADDR_W'(1);
            end
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  // Control registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= FILL;
      wr_ptr_q <= '0;
      addr_q   <= '0;
      slice_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      addr_q   <= addr_d;
      slice_q  <= slice_d;
    end
  end

  // Activation storage; not reset, contents are qualified by the FSM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= bus.i_wr_data;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_fc_ibuf_sliced.sv
`default_nettype none
// ============================================================================
// Module   : tb_fc_ibuf_sliced
// Brief    : Self-checking bench for fc_ibuf_sliced with a behavioural model
//            of the slice/word layout. Honors IBUF_MSB_FIRST_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fc_ibuf_sliced;
  localparam int DS     = 4;
  localparam int SB     = 1;
  localparam int NC     = 2;
  localparam int H      = 2;
  localparam int FL     = 2;
  localparam int BW     = 4;
  localparam int V      = 1;
  localparam int E      = FL * H * NC;
  localparam int OUT_W  = BW * V;
  localparam int NS     = DS / SB;
  localparam int NA     = (E * SB + OUT_W - 1) / OUT_W;
  localparam int TOTAL  = NS * NA;
  localparam int BEAT_W = H * NC * DS;

  typedef logic [H-1:0][NC-1:0][DS-1:0] beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  beat_t ref_mem [FL];
  beat_t stage   [FL];

  always #5 clk = ~clk;

  fc_ibuf_sliced_if #(
    .DATA_SIZE(DS), .SLICE_BITS(SB), .NUM_CHANNELS(NC), .H_CIM_TILES_IN(H),
    .FIFO_LENGTH(FL), .BUS_WIDTH(BW), .V_CIM_TILES_OUT(V)
  ) bus ();

  fc_ibuf_sliced #(
    .DATA_SIZE(DS), .SLICE_BITS(SB), .NUM_CHANNELS(NC), .H_CIM_TILES_IN(H),
    .FIFO_LENGTH(FL), .BUS_WIDTH(BW), .V_CIM_TILES_OUT(V)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: build slice s from element e=(k*NC+j)*H+i, return word a.
  function automatic logic [OUT_W-1:0] exp_word(input int idx);
    logic [NA*OUT_W-1:0] flat;
    int s, a, p, e;
    s = idx / NA;
    a = idx % NA;
`ifdef IBUF_MSB_FIRST_EN
    p = NS - 1 - s;
`else
    p = s;
`endif
    flat = '0;
    for (int k = 0; k < FL; k++)
      for (int j = 0; j < NC; j++)
        for (int i = 0; i < H; i++) begin
          e = (k * NC + j) * H + i;
          for (int b = 0; b < SB; b++)
            flat[e*SB + b] = ref_mem[k][i][j][p*SB + b];
        end
    return flat[a*OUT_W +: OUT_W];
  endfunction

  function automatic int exp_slice(input int idx);
`ifdef IBUF_MSB_FIRST_EN
    return NS - 1 - idx / NA;
`else
    return idx / NA;
`endif
  endfunction

  task automatic check_reset(input string tag);
    chk({tag, "_wr_ready"}, 32'(bus.o_wr_ready), 1);
    chk({tag, "_rd_valid"}, 32'(bus.o_rd_valid), 0);
    chk({tag, "_rd_data"},  32'(bus.o_rd_data),  0);
    chk({tag, "_rd_addr"},  32'(bus.o_rd_addr),  0);
    chk({tag, "_rd_slice"}, 32'(bus.o_rd_slice), 0);
    chk({tag, "_rd_last"},  32'(bus.o_rd_last),  0);
  endtask

  task automatic randomize_stage();
    for (int k = 0; k < FL; k++) stage[k] = beat_t'(BEAT_W'($urandom));
  endtask

  // Write the staged beats with up to max_gap idle cycles before each.
  task automatic fill(input int max_gap);
    int n;
    for (int k = 0; k < FL; k++) begin
      bus.i_wr_valid = 1'b0;
      n = int'($urandom_range(0, max_gap));
      for (int g = 0; g < n; g++) begin
        bus.i_wr_data = beat_t'(BEAT_W'($urandom));
        chk("fill_gap_rd_valid", 32'(bus.o_rd_valid), 0);
        tick();
      end
      chk("fill_wr_ready", 32'(bus.o_wr_ready), 1);
      bus.i_wr_valid = 1'b1;
      bus.i_wr_data  = stage[k];
      tick();
      bus.i_wr_valid = 1'b0;
      chk("fill_rd_valid", 32'(bus.o_rd_valid), (k == FL - 1) ? 1 : 0);
    end
    ref_mem = stage;
  endtask

  // Consume words, checking each against the model; stop_idx >= 0 returns
  // with that word presented and not yet consumed.
  task automatic stream(input bit rand_ready, input int stop_idx);
    int idx = 0;
    int cyc = 0;
    bit rdy;
    while (idx < TOTAL) begin
      if (cyc >= 400) begin
        checks++;
        failures++;
        $error("FAIL stream_timeout observed=%0d words expected=%0d", idx, TOTAL);
        break;
      end
      chk("st_rd_valid", 32'(bus.o_rd_valid), 1);
      chk("st_wr_ready", 32'(bus.o_wr_ready), 0);
      chk("st_rd_data",  32'(bus.o_rd_data),  32'(exp_word(idx)));
      chk("st_rd_addr",  32'(bus.o_rd_addr),  idx % NA);
      chk("st_rd_slice", 32'(bus.o_rd_slice), exp_slice(idx));
      chk("st_rd_last",  32'(bus.o_rd_last),  (idx == TOTAL - 1) ? 1 : 0);
      if (idx == stop_idx) break;
      rdy = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.i_rd_ready = rdy;
      bus.i_wr_valid = 1'($urandom_range(0, 1));
      bus.i_wr_data  = beat_t'(BEAT_W'($urandom));
      tick();
      if (rdy) idx++;
      cyc++;
    end
    bus.i_rd_ready = 1'b0;
    bus.i_wr_valid = 1'b0;
    if (stop_idx < 0) begin
      chk("post_rd_valid", 32'(bus.o_rd_valid), 0);
      chk("post_wr_ready", 32'(bus.o_wr_ready), 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_flush    = 1'b0;
    bus.i_wr_valid = 1'b0;
    bus.i_wr_data  = '0;
    bus.i_rd_ready = 1'b0;

    // Reset state
    repeat (2) tick();
    check_reset("reset");
    rst = 1'b0;
    tick();
    check_reset("idle");

    // Basic fill/stream with the directed pattern
    stage[0] = '0;
    stage[0][0][0] = 4'hF;
    stage[0][1][0] = 4'h0;
    stage[0][0][1] = 4'h1;
    stage[0][1][1] = 4'h2;
    stage[1] = '0;
    fill(0);
`ifdef IBUF_MSB_FIRST_EN
    chk("basic_first_data",  32'(bus.o_rd_data),  32'h1);
    chk("basic_first_slice", 32'(bus.o_rd_slice), 3);
`else
    chk("basic_first_data",  32'(bus.o_rd_data),  32'h5);
`endif
    stream(1'b0, -1);

    // Backpressure with directed data, then random rounds with throttling
    fill(2);
    stream(1'b1, -1);
    for (int r = 0; r < 4; r++) begin
      randomize_stage();
      fill(3);
      stream(1'b1, -1);
    end

    // Flush at slice2 addr1
    randomize_stage();
    fill(1);
    stream(1'b0, 2 * NA + 1);
    bus.i_flush    = 1'b1;
    bus.i_rd_ready = 1'b1;
    tick();
    bus.i_flush    = 1'b0;
    bus.i_rd_ready = 1'b0;
    check_reset("flush_stream");

    // Flush during fill drops the concurrent beat and restarts the fill
    bus.i_wr_valid = 1'b1;
    bus.i_wr_data  = beat_t'(BEAT_W'($urandom));
    tick();
    bus.i_flush    = 1'b1;
    bus.i_wr_data  = beat_t'(BEAT_W'($urandom));
    tick();
    bus.i_flush    = 1'b0;
    bus.i_wr_valid = 1'b0;
    check_reset("flush_fill");
    randomize_stage();
    fill(1);
    stream(1'b1, -1);

    // Asynchronous reset between clock edges mid-stream
    randomize_stage();
    fill(0);
    stream(1'b0, 3);
    #2;
    rst = 1'b1;
    #1;
    check_reset("async_rst");
    tick();
    rst = 1'b0;
    check_reset("async_rst_rel");
    randomize_stage();
    fill(2);
    stream(1'b1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/fc_ibuf_sliced.md
Name: fc_ibuf_sliced

Overview:
Next-generation fully-connected input buffer for the CIM crossbar datapath. Collects FIFO_LENGTH column beats of H_CIM_TILES_IN x NUM_CHANNELS activations from the previous layer's output stage under a valid/ready handshake. Once full, it streams the activations bit-sliced (SLICE_BITS bits per element per slice) as BUS_WIDTH*V_CIM_TILES_OUT-bit words to the crossbar drivers, also under valid/ready. It replaces externally driven write/shift/address control with an internal FSM and sequencing counters.

Parameters:
DATA_SIZE, 8, activation width in bits
SLICE_BITS, 1, bits per element per slice; must divide DATA_SIZE
NUM_CHANNELS, 2, elements per tile per beat
H_CIM_TILES_IN, 4, upstream horizontal tiles
FIFO_LENGTH, 16, beats per fill
BUS_WIDTH, 16, bits per vertical CIM tile
V_CIM_TILES_OUT, 1, downstream vertical tiles
Derived (localparam):
- E = FIFO_LENGTH*H_CIM_TILES_IN*NUM_CHANNELS
- OUT_W = BUS_WIDTH*V_CIM_TILES_OUT
- NUM_SLICES = DATA_SIZE/SLICE_BITS
- NUM_ADDR = ceil(E*SLICE_BITS/OUT_W)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
i_flush  in  1  synchronous abort; discard contents and return to FILL
i_wr_valid  in  1  write beat valid
o_wr_ready  out  1  buffer accepts a beat
i_wr_data  in  [DATA_SIZE-1:0] x [H_CIM_TILES_IN][NUM_CHANNELS]  column beat
o_rd_valid  out  1  o_rd_data valid
i_rd_ready  in  1  consumer accepts word
o_rd_data  out  OUT_W  sliced output word
o_rd_addr  out  clog2(NUM_ADDR) (min 1)  word index within slice
o_rd_slice  out  clog2(NUM_SLICES) (min 1)  current slice index
o_rd_last  out  1  final word of final slice

Behaviour:
- One clock, clk. Reset rst is asynchronous, active-high.
- States: FILL, STREAM. Reset -> FILL, wr_ptr=0, addr=0, slice=0. Storage array is not reset.
- Reset values: o_wr_ready=1, o_rd_valid=0, o_rd_data=0, o_rd_addr=0, o_rd_slice=0, o_rd_last=0.
- FILL: o_wr_ready=1. A write handshake (i_wr_valid&&o_wr_ready) stores the beat at column k=wr_ptr, then wr_ptr++. On the handshake with wr_ptr=FIFO_LENGTH-1, go to STREAM next cycle with wr_ptr=0. Latency: o_rd_valid is high the cycle after the last beat.
- STREAM: o_wr_ready=0, o_rd_valid=1. Writes are ignored.
- Element ordering: element e=(k*NUM_CHANNELS+j)*H_CIM_TILES_IN+i.
- Flat vector for slice s: bits [e*SLICE_BITS +: SLICE_BITS] = element e bits [s*SLICE_BITS +: SLICE_BITS]. Bits from E*SLICE_BITS up to NUM_ADDR*OUT_W-1 are zero.
- Output word: o_rd_data = flat[addr*OUT_W +: OUT_W]. It is combinational from storage and counters, and forced to 0 when o_rd_valid=0.
- Read handshake (o_rd_valid&&i_rd_ready):
  - addr++.
  - At addr=NUM_ADDR-1: addr=0, slice++.
  - At slice=NUM_SLICES-1 and addr=NUM_ADDR-1 (o_rd_last=1): go to FILL, slice=0.
- Stall: with i_rd_ready=0, o_rd_data, o_rd_addr and o_rd_slice hold stable.
- i_flush, in any state: next cycle FILL with all counters 0. Flush has priority over any concurrent handshake, and a concurrent beat is dropped.
- Reset mid-fill or mid-stream: immediately back to the FILL reset state. Partial data is discarded.
- Degenerate case NUM_ADDR=1 or NUM_SLICES=1: counters are tied to 0 and o_rd_last follows the remaining condition.

Optional Feature:
IBUF_MSB_FIRST_EN
- Defined: slices are emitted MSB-first. Physical slice index is NUM_SLICES-1-slice, and o_rd_slice reports the physical index. o_rd_last is unchanged: final handshake of the stream.
- Undefined: LSB-first, as above.

Test Plan:
Config for all tests: DATA_SIZE=4, SLICE_BITS=1, NC=2, FIFO_LENGTH=2, H=2, BUS_WIDTH=4, V=1, giving E=8, NUM_ADDR=2, NUM_SLICES=4.
- Basic fill/stream: beat0 {[0][0]=F,[1][0]=0,[0][1]=1,[1][1]=2}, beat1 all 0. Expected: o_rd_valid rises the cycle after beat1; slice0 addr0=4'h5; slice1 addr0=4'h9; addr1=0 in all slices; 8 words total; o_rd_last on the 8th; o_wr_ready=1 the next cycle.
- Backpressure: same data with i_rd_ready toggled 1,0,0,1. Expected: word held constant during stall; no word skipped or repeated.
- Write throttle: i_wr_valid gaps between beats. Expected: STREAM entered only after 2 accepted beats; i_wr_valid during STREAM ignored and data unchanged.
- Flush: assert i_flush at slice2 addr1. Expected: next cycle o_rd_valid=0, o_wr_ready=1; the new fill streams from slice0 addr0.
- Async reset: pulse rst mid-STREAM between clock edges. Expected: outputs return to reset values before the next edge.
- MSB-first (IBUF_MSB_FIRST_EN defined): basic data. Expected: first word o_rd_slice=3, data=4'h1; the final word carries slice0.
